// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the sysid checker.
package sysid_checker_pkg;

    localparam int unsigned CNT_W   = 16;
    localparam logic        ADDR_ID = 1'b0;
    localparam logic        ADDR_TS = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        RD_TS,
        CMP,
        DONE
    } state_e;

endpackage

// File: rtl/sysid_checker.sv
// Reads the ID and timestamp words from an Avalon-MM sysid slave and
// compares them against the expected build values.
// Optional macro SYSID_CHECKER_TIMEOUT_EN adds a bounded waitrequest counter.
module sysid_checker
    import sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXP_ID         = 32'h0000_0000,
    parameter logic [31:0] EXP_TS         = 32'd1476855466,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        av_address,
    output logic        av_read,
    input  logic [31:0] av_readdata,
    input  logic        av_waitrequest,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        busy,
    output logic        done,
    output logic        match,
    output logic        timeout
);

    // Elaboration-time range guard on the wait budget.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..65535");
    end

    state_e      state_q, state_d;
    logic        auto_q, auto_d;
    logic        rd_q, rd_d;
    logic        addr_q, addr_d;
    logic [31:0] id_q, id_d;
    logic [31:0] ts_q, ts_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        match_q, match_d;
    logic        tmo_q, tmo_d;
    logic        to_hit;

`ifdef SYSID_CHECKER_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Last allowed stall cycle of the current read.
    assign to_hit = (state_q == RD_ID || state_q == RD_TS) && av_waitrequest
                    && (cnt_q == TO_LAST);

    // Stall counter: counts waitrequest cycles, cleared on every state change.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == RD_ID || state_q == RD_TS) && av_waitrequest) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // Stall counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    // Next-state, capture and flag logic; bus strobes follow the next state.
    always_comb begin
        state_d = state_q;
        auto_d  = auto_q;
        id_d    = id_q;
        ts_d    = ts_q;
        match_d = match_q;
        tmo_d   = tmo_q;

        unique case (state_q)
            IDLE: begin
                if (start || auto_q) begin
                    state_d = RD_ID;
                    auto_d  = 1'b0;
                end
            end
            RD_ID: begin
                if (!av_waitrequest) begin
                    id_d    = av_readdata;
                    state_d = RD_TS;
                end else if (to_hit) begin
                    state_d = DONE;
                    tmo_d   = 1'b1;
                    match_d = 1'b0;
                end
            end
            RD_TS: begin
                if (!av_waitrequest) begin
                    ts_d    = av_readdata;
                    state_d = CMP;
                end else if (to_hit) begin
                    state_d = DONE;
                    tmo_d   = 1'b1;
                    match_d = 1'b0;
                end
            end
            CMP: begin
                match_d = (id_q == EXP_ID) && (ts_q == EXP_TS);
                state_d = DONE;
            end
            DONE: begin
                if (start) begin
                    state_d = RD_ID;
                    match_d = 1'b0;
                    tmo_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        rd_d   = (state_d == RD_ID) || (state_d == RD_TS);
        addr_d = (state_d == RD_TS) ? ADDR_TS : ADDR_ID;
        busy_d = rd_d || (state_d == CMP);
        done_d = (state_d == DONE);
    end

    // State and registered outputs; auto-start re-arms on every reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            auto_q  <= AUTO_START;
            rd_q    <= 1'b0;
            addr_q  <= ADDR_ID;
            id_q    <= '0;
            ts_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            auto_q  <= auto_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            id_q    <= id_d;
            ts_q    <= ts_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            match_q <= match_d;
            tmo_q   <= tmo_d;
        end
    end

    assign av_read    = rd_q;
    assign av_address = addr_q;
    assign id_value   = id_q;
    assign ts_value   = ts_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign match      = match_q;
    assign timeout    = tmo_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker with a small sysid slave model.
module tb_sysid_checker;

    localparam logic [31:0] EXP_TS = 32'd1476855466;
    localparam logic [31:0] JUNK   = 32'hDEAD_BEEF;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        av_address;
    logic        av_read;
    logic [31:0] av_readdata;
    logic        av_waitrequest;
    logic [31:0] id_value;
    logic [31:0] ts_value;
    logic        busy;
    logic        done;
    logic        match;
    logic        timeout;

    logic [31:0] id_word;
    logic [31:0] ts_word;
    logic        stuck;
    int          ts_waits;
    int          ts_seen = 0;
    int          errors  = 0;
    int          checks  = 0;

    sysid_checker #(
        .EXP_ID         (32'h0000_0000),
        .EXP_TS         (EXP_TS),
        .TIMEOUT_CYCLES (8),
        .AUTO_START     (1'b1)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .av_address     (av_address),
        .av_read        (av_read),
        .av_readdata    (av_readdata),
        .av_waitrequest (av_waitrequest),
        .id_value       (id_value),
        .ts_value       (ts_value),
        .busy           (busy),
        .done           (done),
        .match          (match),
        .timeout        (timeout)
    );

    always #5 clock = ~clock;

    // Slave: optional stalls on the timestamp read; junk data while stalled.
    assign av_waitrequest = stuck || (av_read && av_address && (ts_seen < ts_waits));
    assign av_readdata    = av_waitrequest ? JUNK : (av_address ? ts_word : id_word);

    always @(posedge clock) begin
        if (av_read && av_address) ts_seen <= ts_seen + 1;
        else                       ts_seen <= 0;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, output int cycles);
        cycles = 0;
        while (cycles < max_cycles && done !== 1'b1) begin
            @(negedge clock);
            cycles++;
        end
    endtask

    task automatic test_reset();
        #3;
        checks++; if (av_read !== 1'b0)  begin errors++; $display("FAIL rst_av_read got %b want 0", av_read); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL rst_done got %b want 0", done); end
        checks++; if (id_value !== 32'd0) begin errors++; $display("FAIL rst_id got %h want 0", id_value); end
        checks++; if (timeout !== 1'b0 || match !== 1'b0 || av_address !== 1'b0)
            begin errors++; $display("FAIL rst_flags got t=%b m=%b a=%b want 0", timeout, match, av_address); end
    endtask

    task automatic test_auto_start();
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checks++; if (av_read !== 1'b1 || av_address !== 1'b0 || busy !== 1'b1)
            begin errors++; $display("FAIL auto_rd_id got r=%b a=%b b=%b want 1 0 1", av_read, av_address, busy); end
        @(negedge clock);
        checks++; if (av_read !== 1'b1 || av_address !== 1'b1)
            begin errors++; $display("FAIL auto_rd_ts got r=%b a=%b want 1 1", av_read, av_address); end
        @(negedge clock);
        checks++; if (av_read !== 1'b0 || busy !== 1'b1 || done !== 1'b0)
            begin errors++; $display("FAIL auto_cmp got r=%b b=%b d=%b want 0 1 0", av_read, busy, done); end
        @(negedge clock);
        checks++; if (done !== 1'b1 || match !== 1'b1 || busy !== 1'b0)
            begin errors++; $display("FAIL auto_done got d=%b m=%b b=%b want 1 1 0", done, match, busy); end
        checks++; if (id_value !== 32'd0 || ts_value !== EXP_TS)
            begin errors++; $display("FAIL auto_values got id=%h ts=%h want 0 %h", id_value, ts_value, EXP_TS); end
    endtask

    task automatic test_ts_wait();
        int n_hold;
        int cyc;
        ts_waits = 3;
        pulse_start();
        @(negedge clock);
        n_hold = 0;
        while (n_hold < 10 && av_read === 1'b1 && av_address === 1'b1) begin
            checks++; if (ts_value === JUNK)
                begin errors++; $display("FAIL wait_no_capture got ts=%h during stall", ts_value); end
            n_hold++;
            @(negedge clock);
        end
        checks++; if (n_hold !== 4)
            begin errors++; $display("FAIL wait_hold_cycles got %0d want 4", n_hold); end
        wait_done(5, cyc);
        checks++; if (done !== 1'b1 || match !== 1'b1 || ts_value !== EXP_TS)
            begin errors++; $display("FAIL wait_result got d=%b m=%b ts=%h want 1 1 %h", done, match, ts_value, EXP_TS); end
        ts_waits = 0;
    endtask

    task automatic test_busy_ignore();
        pulse_start();
        start = 1'b1;
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        start = 1'b0;
        checks++; if (done !== 1'b1)
            begin errors++; $display("FAIL busy_first_done got %b want 1", done); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++; if (done !== 1'b1 || busy !== 1'b0 || av_read !== 1'b0)
                begin errors++; $display("FAIL busy_not_queued cyc %0d got d=%b b=%b r=%b want 1 0 0", i, done, busy, av_read); end
        end
    endtask

    task automatic test_mismatch();
        int cyc;
        id_word = 32'h0000_0001;
        pulse_start();
        checks++; if (done !== 1'b0 || match !== 1'b0 || busy !== 1'b1)
            begin errors++; $display("FAIL mis_restart got d=%b m=%b b=%b want 0 0 1", done, match, busy); end
        wait_done(10, cyc);
        checks++; if (cyc !== 3)
            begin errors++; $display("FAIL mis_latency got %0d want 3", cyc); end
        checks++; if (done !== 1'b1 || match !== 1'b0 || id_value !== 32'd1)
            begin errors++; $display("FAIL mis_result got d=%b m=%b id=%h want 1 0 1", done, match, id_value); end
    endtask

    task automatic test_reset_restart();
        int cyc;
        pulse_start();
        checks++; if (av_read !== 1'b1 || av_address !== 1'b0)
            begin errors++; $display("FAIL rr_in_rd_id got r=%b a=%b want 1 0", av_read, av_address); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (av_read !== 1'b0 || busy !== 1'b0 || id_value !== 32'd0 || ts_value !== 32'd0)
            begin errors++; $display("FAIL rr_async got r=%b b=%b id=%h ts=%h want 0", av_read, busy, id_value, ts_value); end
        id_word = 32'd0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        wait_done(10, cyc);
        checks++; if (cyc !== 4)
            begin errors++; $display("FAIL rr_latency got %0d want 4", cyc); end
        checks++; if (done !== 1'b1 || match !== 1'b1 || ts_value !== EXP_TS)
            begin errors++; $display("FAIL rr_result got d=%b m=%b ts=%h want 1 1 %h", done, match, ts_value, EXP_TS); end
    endtask

    task automatic test_timeout();
        int n_rd;
        stuck = 1'b1;
        pulse_start();
`ifdef SYSID_CHECKER_TIMEOUT_EN
        n_rd = 0;
        while (n_rd < 20 && av_read === 1'b1) begin
            n_rd++;
            @(negedge clock);
        end
        checks++; if (n_rd !== 8)
            begin errors++; $display("FAIL to_read_cycles got %0d want 8", n_rd); end
        checks++; if (done !== 1'b1 || timeout !== 1'b1 || match !== 1'b0)
            begin errors++; $display("FAIL to_result got d=%b t=%b m=%b want 1 1 0", done, timeout, match); end
`else
        n_rd = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            if (av_read === 1'b1) n_rd++;
        end
        checks++; if (n_rd !== 1000)
            begin errors++; $display("FAIL to_read_held got %0d want 1000", n_rd); end
        checks++; if (busy !== 1'b1 || done !== 1'b0 || timeout !== 1'b0)
            begin errors++; $display("FAIL to_still_busy got b=%b d=%b t=%b want 1 0 0", busy, done, timeout); end
`endif
        stuck = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        stuck    = 1'b0;
        ts_waits = 0;
        id_word  = 32'd0;
        ts_word  = EXP_TS;

        test_reset();
        test_auto_start();
        test_ts_wait();
        test_busy_ignore();
        test_mismatch();
        test_reset_restart();
        test_timeout();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sysid_checker.md
SYSID_CHECKER -- requirements
Module: sysid_checker

Interface
REQ-001 SHALL have parameter EXP_ID, default 32'h0000_0000, the expected system ID word at address 0.
REQ-002 SHALL have parameter EXP_TS, default 32'd1476855466, the expected timestamp word at address 1.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum consecutive waitrequest cycles per read (range 1..65535).
REQ-004 SHALL have parameter AUTO_START, default 1; when 1, a check starts automatically after reset.
REQ-005 SHALL have port clock, input, 1 bit: the single clock; all logic rising-edge.
REQ-006 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port start, input, 1 bit: request a check; sampled only in IDLE or DONE.
REQ-008 SHALL have port av_address, output, 1 bit: Avalon-MM word address to the sysid slave.
REQ-009 SHALL have port av_read, output, 1 bit: Avalon-MM read strobe.
REQ-010 SHALL have port av_readdata, input, 32 bits: read data, valid in the cycle av_read=1 and av_waitrequest=0.
REQ-011 SHALL have port av_waitrequest, input, 1 bit: slave stall; tie 0 for zero-wait slaves.
REQ-012 SHALL have ports id_value and ts_value, output, 32 bits each: captured words.
REQ-013 SHALL have ports busy, done, match and timeout, output, 1 bit each: status flags.

Function
REQ-014 SHALL implement states IDLE, RD_ID, RD_TS, CMP, DONE.
REQ-015 IDLE: start=1 (or first cycle after reset release with AUTO_START=1) SHALL move to RD_ID next cycle; otherwise remain.
REQ-016 RD_ID SHALL drive av_read=1, av_address=0; on av_waitrequest=0 it SHALL capture av_readdata into id_value and move to RD_TS.
REQ-017 RD_TS SHALL drive av_read=1, av_address=1; on av_waitrequest=0 it SHALL capture into ts_value and move to CMP.
REQ-018 av_read and av_address SHALL be held stable while av_waitrequest=1.
REQ-019 CMP SHALL last exactly one cycle, set match=(id_value==EXP_ID)&&(ts_value==EXP_TS), and move to DONE.
REQ-020 DONE SHALL hold done=1 and match/timeout stable; start=1 SHALL clear done, match, timeout and move to RD_ID.
REQ-021 busy SHALL be 1 in RD_ID, RD_TS, CMP and 0 otherwise; av_read SHALL be 0 outside RD_ID/RD_TS.
REQ-022 With av_waitrequest=0 throughout, start sampled in cycle N SHALL give av_read in N+1 and N+2, and done=1 from N+4.
REQ-023 start asserted while busy=1 SHALL be ignored, not queued.
REQ-024 id_value and ts_value SHALL change only at a capture edge and persist until the next capture.

Reset
REQ-025 reset_n=0 SHALL immediately force state IDLE, av_read=0, av_address=0, id_value=0, ts_value=0, busy=0, done=0, match=0, timeout=0, wait counter=0.
REQ-026 Reset asserted mid-read SHALL abort the transaction with no capture; AUTO_START SHALL re-arm on release.

Configuration
REQ-027 Macro SYSID_CHECKER_TIMEOUT_EN, when defined, SHALL compile in a wait counter that increments each RD_ID/RD_TS cycle with av_waitrequest=1 and clears on each state change.
REQ-028 With SYSID_CHECKER_TIMEOUT_EN, the counter reaching TIMEOUT_CYCLES SHALL drop av_read next cycle and enter DONE with timeout=1, match=0, skipping CMP.
REQ-029 Without SYSID_CHECKER_TIMEOUT_EN, the counter SHALL be absent, reads SHALL wait indefinitely, and timeout SHALL be constant 0.

Structure
REQ-030 A shared package sysid_checker_pkg SHALL hold the state enum, address constants ADDR_ID=0 and ADDR_TS=1, and the counter width constant (16).
REQ-031 The block SHALL be a single module; no sub-module is required.

Verification
REQ-032 AUTO_START=1, slave returns 0 at addr 0 and 1476855466 at addr 1, no waits -> done=1 four cycles after reset release, match=1, id_value=0, ts_value=1476855466.
REQ-033 Slave returns 32'h0000_0001 at addr 0 -> done=1, match=0, id_value=1.
REQ-034 av_waitrequest=1 for 3 cycles in RD_TS -> av_read/av_address=1 held stable for 4 cycles, single capture, match=1.
REQ-035 With SYSID_CHECKER_TIMEOUT_EN, TIMEOUT_CYCLES=8, waitrequest stuck 1 -> av_read drops and done=1, timeout=1, match=0 after 8 wait cycles; without the macro -> still busy after 1000 cycles.
REQ-036 start pulsed while busy, then reset_n pulsed low during RD_ID -> extra start ignored; reset clears all outputs to 0 asynchronously, and the check restarts and completes with match=1.
